// File: rtl/simon_pkg.sv
// Shared constants, state encoding and word helpers for the SIMON32/64 key schedule.
package simon_pkg;

  localparam int SIMON_WORD_W    = 16;
  localparam int SIMON_KEY_WORDS = 4;

  // Round constant c = 2^16 - 4, which folds the "~k ^ 3" of the classic recurrence.
  localparam logic [SIMON_WORD_W-1:0] SIMON_C = 16'hFFFC;

  // Sequence z0; z[i] is read left to right, so z[i] = SIMON_Z0[61-i].
  localparam logic [61:0] SIMON_Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } ks_state_t;

  // Rotate a 16-bit word right by n (0 < n < 16).
  function automatic logic [SIMON_WORD_W-1:0] rotr16(input logic [SIMON_WORD_W-1:0] v,
                                                     input int unsigned n);
    return (v >> n) | (v << (SIMON_WORD_W - n));
  endfunction

  // Bit i of z0 in left-to-right order.
  function automatic logic z0_bit(input logic [5:0] i);
    return SIMON_Z0[6'd61 - i];
  endfunction

endpackage

// File: rtl/simon_ks_mix.sv
// Nonlinear-free mixing term of the SIMON32/64 key recurrence:
// t = rotr(a,3) ^ b; mix = t ^ rotr(t,1).
module simon_ks_mix
  import simon_pkg::*;
(
  input  logic [SIMON_WORD_W-1:0] i_a,
  input  logic [SIMON_WORD_W-1:0] i_b,
  output logic [SIMON_WORD_W-1:0] o_mix
);

  logic [SIMON_WORD_W-1:0] w_t;

  // Pure XOR/rotate network, no carries.
  always_comb begin
    w_t   = rotr16(i_a, 3) ^ i_b;
    o_mix = w_t ^ rotr16(w_t, 1);
  end

endmodule

// File: rtl/simon_key_schedule.sv
// SIMON32/64 key schedule feeding a decrypt datapath: expands the master key
// forward in a 4-word window, then walks back emitting k[ROUNDS-1] .. k0.
module simon_key_schedule
  import simon_pkg::*;
#(
  parameter int ROUNDS = 32
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [63:0]             key_in,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [SIMON_WORD_W-1:0] rk,
  output logic [4:0]              rk_idx,
  output logic                    rk_last,
  output logic                    busy
);

  // Window base reached on the final forward step, and the index emitted first.
  localparam logic [5:0] B_LAST    = 6'(ROUNDS - 5);
  localparam logic [4:0] IDX_FIRST = 5'(ROUNDS - 1);

  ks_state_t r_state;
  ks_state_t w_state_nxt;

  // Window: r_w0..r_w3 hold k[b]..k[b+3].
  logic [SIMON_WORD_W-1:0] r_w0;
  logic [SIMON_WORD_W-1:0] r_w1;
  logic [SIMON_WORD_W-1:0] r_w2;
  logic [SIMON_WORD_W-1:0] r_w3;
  logic [5:0]              r_b;
  logic [4:0]              r_rk_idx;

  logic [SIMON_WORD_W-1:0] w_fwd_mix;
  logic [SIMON_WORD_W-1:0] w_bwd_mix;
  logic [SIMON_WORD_W-1:0] w_k_fwd;
  logic [SIMON_WORD_W-1:0] w_k_bwd;
  logic [5:0]              w_b_dec;
  logic                    w_key_acc;
  logic                    w_hs;

  // Forward operands produce k[b+4].
  simon_ks_mix u_mix_fwd (
    .i_a   (r_w3),
    .i_b   (r_w1),
    .o_mix (w_fwd_mix)
  );

  // Backward operands recover k[b-1] from the same recurrence solved for its oldest term.
  simon_ks_mix u_mix_bwd (
    .i_a   (r_w2),
    .i_b   (r_w0),
    .o_mix (w_bwd_mix)
  );

  // New-word candidates for both directions; b-1 is clamped so z is never indexed past its end.
  always_comb begin
    w_b_dec   = (r_b == 6'd0) ? 6'd0 : (r_b - 6'd1);
    w_k_fwd   = r_w0 ^ SIMON_C ^ {15'd0, z0_bit(r_b)} ^ w_fwd_mix;
    w_k_bwd   = r_w3 ^ SIMON_C ^ {15'd0, z0_bit(w_b_dec)} ^ w_bwd_mix;
    w_key_acc = key_valid & key_ready;
    w_hs      = rk_valid & rk_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: idle -> expand for ROUNDS-4 steps -> emit until index 0 is taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_key_acc)                          w_state_nxt = EXPAND;
      EXPAND:  if (r_b == B_LAST)                      w_state_nxt = EMIT;
      EMIT:    if (w_hs && (r_rk_idx == 5'd0))         w_state_nxt = IDLE;
      default:                                         w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; rk is forced to zero whenever it is not valid.
  always_comb begin
    key_ready = (r_state == IDLE);
    rk_valid  = (r_state == EMIT);
    busy      = (r_state == EXPAND) || (r_state == EMIT);
    rk        = rk_valid ? r_w3 : '0;
    rk_idx    = r_rk_idx;
    rk_last   = rk_valid && (r_rk_idx == 5'd0);
  end

  // Window, base counter and emit index; everything holds while a key is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w0     <= '0;
      r_w1     <= '0;
      r_w2     <= '0;
      r_w3     <= '0;
      r_b      <= '0;
      r_rk_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_key_acc) begin
            r_w0 <= key_in[15:0];
            r_w1 <= key_in[31:16];
            r_w2 <= key_in[47:32];
            r_w3 <= key_in[63:48];
            r_b  <= '0;
          end
        end
        EXPAND: begin
          r_w0     <= r_w1;
          r_w1     <= r_w2;
          r_w2     <= r_w3;
          r_w3     <= w_k_fwd;
          r_b      <= r_b + 6'd1;
          r_rk_idx <= IDX_FIRST;
        end
        EMIT: begin
          if (w_hs) begin
            r_w3 <= r_w2;
            r_w2 <= r_w1;
            r_w1 <= r_w0;
            // Once the window bottoms out at k0 the remaining words are already held.
            if (r_b != 6'd0) begin
              r_w0 <= w_k_bwd;
              r_b  <= r_b - 6'd1;
            end
            if (r_rk_idx != 5'd0) begin
              r_rk_idx <= r_rk_idx - 5'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench for simon_key_schedule (ROUNDS=32).
module tb_simon_key_schedule;

  localparam logic [63:0] TV_KEY = 64'h1918_1110_0908_0100;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
  logic        rk_valid;
  logic        rk_ready;
  logic [15:0] rk;
  logic [4:0]  rk_idx;
  logic        rk_last;
  logic        busy;

  simon_key_schedule #(.ROUNDS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk        (rk),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] key;
    bit          stall;    // pseudo-random rk_ready
    bit          pulse;    // key_valid pulsed in EXPAND and EMIT
    int          rst_exp;  // EXPAND cycle to reset in (0 = none)
    int          rst_idx;  // rk_idx to reset at during EMIT (-1 = none)
  } vec_t;

  vec_t        tbl[9];
  logic [15:0] ks_exp[0:31];
  logic [15:0] got[0:31];
  int          n_vec;
  int          n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference schedule in the classic form: k[i] = ~k[i-4] ^ t ^ z ^ 3.
  task automatic build_model(input logic [63:0] key);
    logic [15:0] k[0:31];
    logic [15:0] t;
    logic [61:0] zv;
    zv = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t    = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
      t    = t ^ {t[0], t[15:1]};
      k[i] = ~k[i-4] ^ t ^ {15'd0, zv[61-(i-4)]} ^ 16'd3;
    end
    for (int i = 0; i < 32; i++) ks_exp[i] = k[i];
  endtask

  function automatic logic [15:0] simon_f(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  task automatic reset_pulse(input string tag);
    rst_n     = 1'b0;
    key_valid = 1'b0;
    rk_ready  = 1'b1;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    rk_ready = 1'b0;
    check(tag, 64'({key_ready, rk_valid, rk, rk_idx, rk_last, busy}),
          64'({1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0}));
  endtask

  task automatic run_seq(input vec_t v);
    int          cyc;
    int          n;
    int          idx;
    int          guard;
    bit          rdy;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] nx;
    build_model(v.key);
    check("key_ready_idle", 64'(key_ready), 64'd1);
    key_in    = v.key;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_in    = ~v.key;
    cyc = 1;
    while (!rk_valid && cyc < 200) begin
      key_valid = 1'b0;
      if (cyc == 5) check("busy_expand", 64'({busy, key_ready}), 64'b10);
      if (v.pulse && cyc == 10) begin
        key_valid = 1'b1;
        check("key_ready_expand", 64'(key_ready), 64'd0);
      end
      if (v.rst_exp != 0 && cyc == v.rst_exp) begin
        reset_pulse("reset_in_expand");
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    key_valid = 1'b0;
    check("first_valid_cycle", 64'(cyc), 64'd29);

    n = 0; idx = 31; guard = 0;
    while (n < 32 && guard < 400) begin
      key_valid = v.pulse && (n == 5);
      if (v.pulse && n == 5) check("key_ready_emit", 64'(key_ready), 64'd0);
      check("rk_word", 64'({rk_valid, rk_idx, rk, rk_last}),
            64'({1'b1, 5'(idx), ks_exp[idx], (idx == 0)}));
      if (v.rst_idx >= 0 && idx == v.rst_idx) begin
        reset_pulse("reset_in_emit");
        return;
      end
      rdy      = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      if (rdy) begin
        got[n] = rk;
        n++;
        idx--;
      end
      guard++;
      @(posedge clk); #1;
    end
    rk_ready  = 1'b0;
    key_valid = 1'b0;
    check("emit_count", 64'(n), 64'd32);
    if (!v.stall) check("emit_cycles", 64'(guard), 64'd32);
    check("back_to_idle", 64'({key_ready, rk_valid, busy, rk_last}), 64'b1000);
    if (v.key == TV_KEY) begin
      check("last_four", {got[28], got[29], got[30], got[31]}, 64'h1918_1110_0908_0100);
      x = 16'hc69b;
      y = 16'he9bb;
      for (int r = 0; r < 32; r++) begin
        nx = y;
        y  = x ^ simon_f(y) ^ got[r];
        x  = nx;
      end
      check("plaintext", 64'({x, y}), 64'h6565_6877);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{TV_KEY,                1'b0, 1'b0, 0,  -1};
    tbl[1] = '{TV_KEY,                1'b1, 1'b0, 0,  -1};
    tbl[2] = '{TV_KEY,                1'b0, 1'b1, 0,  -1};
    tbl[3] = '{TV_KEY,                1'b0, 1'b0, 10, -1};
    tbl[4] = '{TV_KEY,                1'b0, 1'b0, 0,  -1};
    tbl[5] = '{TV_KEY,                1'b0, 1'b0, 0,  17};
    tbl[6] = '{TV_KEY,                1'b1, 1'b0, 0,  -1};
    tbl[7] = '{64'h0,                 1'b0, 1'b0, 0,  -1};
    tbl[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0,  -1};

    rst_n     = 1'b0;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    key_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_state", 64'({key_ready, rk_valid, rk, rk_idx, rk_last, busy}),
          64'({1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0}));

    for (int i = 0; i < 9; i++) run_seq(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
